// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the two-requester ALU arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b0100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU: add/sub wrap modulo 2^WIDTH, signed set-less-than, shift-left-by-2.
// Undefined opcodes yield zero.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: y = a << 2;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; the result is registered at the accepting edge and held
// until the granted requester consumes it. Define ALU_ARBITER_FIXED_PRIO_EN for req0-wins-ties.
//
// Handshake: a request transfers on an edge where reqi_valid & reqi_ready; a response
// transfers on an edge where rspi_valid & rspi_ready. Valid may drop before acceptance.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output arb_state_e       dbg_state
);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             win_is_1;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  always_comb begin
    win_is_1 = req1_valid & ~req0_valid;
  end
`else
  // Pointer holds the index of the last granted requester; the other one wins ties.
  logic last_grant_q, last_grant_d;

  always_comb begin
    win_is_1 = req1_valid & (~req0_valid | ~last_grant_q);
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && (req0_valid || req1_valid)) last_grant_d = win_is_1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    alu_op = win_is_1 ? req1_op : req0_op;
    alu_a  = win_is_1 ? req1_a  : req0_a;
    alu_b  = win_is_1 ? req1_b  : req0_b;
  end

  alu_exec #(.WIDTH(WIDTH)) u_alu_exec (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    result_d   = result_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = req0_valid & ~win_is_1;
        req1_ready = win_is_1;
        if (req0_valid || req1_valid) begin
          state_d  = ST_BUSY;
          grant_d  = win_is_1;
          result_d = alu_y;
        end
      end
      ST_BUSY: begin
        if (grant_q ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      result_q <= result_d;
    end
  end

  assign busy       = (state_q == ST_BUSY);
  assign rsp0_valid = busy & ~grant_q;
  assign rsp1_valid = busy & grant_q;
  assign rsp_data   = result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed expected values.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk, rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         busy;
  arb_state_e   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .busy(busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    check({tag, ".rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
  endtask

  // One transaction: present requests, check grant, check response, consume it.
  task automatic run_op(input string tag,
                        input logic v0, input logic [3:0] op0, input logic [W-1:0] a0, b0,
                        input logic v1, input logic [3:0] op1, input logic [W-1:0] a1, b1,
                        input logic exp_g, input logic [W-1:0] exp_d);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    check({tag, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, ~exp_g});
    check({tag, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, exp_g});
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".rsp0_valid"}, {31'd0, rsp0_valid}, {31'd0, ~exp_g});
    check({tag, ".rsp1_valid"}, {31'd0, rsp1_valid}, {31'd0, exp_g});
    check({tag, ".data"}, rsp_data, exp_d);
    if (exp_g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check_quiet({tag, ".done"});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    #2;
    check_quiet("reset");
    check("reset.data", rsp_data, 32'd0);
    do_reset();

    run_op("add7_5", 1, ALU_ADD, 32'd7, 32'd5, 0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd12);

    // Round-robin from a fresh reset.
    do_reset();
    run_op("tie1", 1, ALU_ADD, 32'd1, 32'd1, 1, ALU_SUB, 32'd10, 32'd3, 1'b0, 32'd2);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    run_op("tie2", 1, ALU_ADD, 32'd1, 32'd1, 1, ALU_SUB, 32'd10, 32'd3, 1'b0, 32'd2);
    run_op("tie3", 1, ALU_AND, 32'hF, 32'h3, 1, ALU_SUB, 32'd10, 32'd3, 1'b0, 32'h3);
`else
    run_op("tie2", 1, ALU_ADD, 32'd1, 32'd1, 1, ALU_SUB, 32'd10, 32'd3, 1'b1, 32'd7);
    run_op("tie3", 1, ALU_AND, 32'hF, 32'h3, 1, ALU_SUB, 32'd10, 32'd3, 1'b0, 32'h3);
`endif

    run_op("slt_neg", 1, ALU_SLT, -32'sd3, 32'd2, 0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd1);
    run_op("slt_pos", 0, 4'd0, 32'd0, 32'd0, 1, ALU_SLT, 32'd2, -32'sd3, 1'b1, 32'd0);
    run_op("sub0_1", 1, ALU_SUB, 32'd0, 32'd1, 0, 4'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
    run_op("sll3", 0, 4'd0, 32'd0, 32'd0, 1, ALU_SLL, 32'd3, 32'd99, 1'b1, 32'd12);
    run_op("undef", 1, 4'b1111, 32'd5, 32'd6, 0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    run_op("and", 1, ALU_AND, 32'hF0F0, 32'hFF00, 0, 4'd0, 32'd0, 32'd0, 1'b0, 32'h0000_F000);
    run_op("or", 0, 4'd0, 32'd0, 32'd0, 1, ALU_OR, 32'hF0F0, 32'hFF00, 1'b1, 32'h0000_FFF0);
    run_op("nor", 1, ALU_NOR, 32'h0, 32'h0000_00FF, 0, 4'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FF00);
    run_op("add_wrap", 1, ALU_ADD, 32'hFFFF_FFFF, 32'd2, 0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd1);

    // Request withdrawn before any edge, with rsp0_ready high while idle.
    req0_valid = 1'b1; req0_op = ALU_ADD; rsp0_ready = 1'b1;
    #1;
    check("withdraw.req0_ready", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    step();
    rsp0_ready = 1'b0;
    check_quiet("withdraw");

    // Stall: rsp1 held off for 5 cycles, rsp0_ready and new requests must be ignored.
    req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'd100; req1_b = 32'd23;
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd9; req0_b = 32'd1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall.rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("stall.rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("stall.data", rsp_data, 32'd123);
      check("stall.busy", {31'd0, busy}, 32'd1);
      check("stall.readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
    end
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    check_quiet("stall.done");

    // Reset while busy discards the operation.
    req0_valid = 1'b1; req0_op = ALU_OR; req0_a = 32'h5; req0_b = 32'hA;
    step();
    req0_valid = 1'b0;
    check("rbusy.pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("rbusy.async");
    check("rbusy.data", rsp_data, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("rbusy.after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    n_err++;
    $display("FAIL timeout: observed no completion expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
